mskaes_out_unmask_serializer: RTL and testbench
===============================================

// Module: mskaes_out_unmask_serializer
// PURPOSE
//   Downstream stage of the masked 32-bit AES core. Fetches the d-share masked ciphertext over
//   the core's sticky valid/ready output interface and recombines the shares by XOR. Streams the
//   128-bit unmasked ciphertext as four 32-bit words on a valid/ready port toward the host bus.
//   Holds one block; no combinational path exists between dout_ready and core_out_ready.
// PARAMETERS
//   d      2    number of shares (>=2)
//   BLK    128  block width in bits (fixed, AES)
//   WORD   32   output word width; BLK/WORD = 4 words per block
// PORTS
//   clk               in   1        clock, all logic on rising edge
//   rst               in   1        synchronous, active-high reset
//   core_cipher_valid in   1        core output valid; sticky until fetched
//   core_out_ready    out  1        this block accepts a masked ciphertext (registered)
//   core_sh_data_out  in   BLK*d    masked ciphertext; bit i share j at index i*d+j
//   dout_valid        out  1        dout holds a valid word (registered)
//   dout_ready        in   1        host accepts word
//   dout              out  WORD     ciphertext word; word 0 = bits [127:96], word 3 = bits [31:0]
//   dout_last         out  1        dout is word 3 of the block
//   busy              out  1        block held (state != EMPTY)
// BEHAVIOUR
//   Reset: state=EMPTY, word_cnt=0, data reg=0; core_out_ready=1 from the first cycle after rst
//     deasserts, 0 while rst high. dout_valid=0, dout=0, dout_last=0, busy=0.
//   FSM, 2 states:
//     EMPTY: core_out_ready=1. On core_cipher_valid&core_out_ready (fetch): data reg <=
//       XOR over j of core_sh_data_out[i*d+j] for each bit i; word_cnt<=0; -> SEND.
//       No fetch: stay, data reg unchanged (0 or last sent block cleared, see below).
//     SEND: core_out_ready=0, dout_valid=1, dout=data reg word[word_cnt], dout_last=(word_cnt==3).
//       dout_valid&dout_ready: word_cnt<=word_cnt+1; if word_cnt==3 -> EMPTY, data reg<=0,
//       word_cnt<=0. dout_valid&~dout_ready: hold dout, dout_last, word_cnt (stable until accepted).
//   Latency: fetch at cycle t -> dout_valid=1 with word 0 at t+1. Back-to-back words: one per cycle
//     while dout_ready=1. Last word accepted at t -> core_out_ready=1 at t+1; next fetch at t+1
//     earliest, so minimum 5 cycles per block (one bubble between blocks).
//   core_out_ready and dout_valid are decoded from the state register only (no input-to-output
//     combinational path, SVRS compliant).
//   Shares are recombined only at the capture register input; the masked bus is never registered
//     share-wise here. data reg cleared on block completion and on reset.
//   core_cipher_valid with core_out_ready=0: ignored, core holds its output (sticky).
//   core_sh_data_out sampled only on the fetch cycle; changes at other cycles have no effect.
//   dout_ready while dout_valid=0: ignored, no state change.
//   word_cnt 2 bits; wrap 3->0 only on block completion.
//   rst mid-block: abandons the block, returns to reset state next cycle, no word emitted.
// TESTING
//   1 FIPS-197 C.1: d=2, share0=random R, share1=R^69c4e0d86a7b0430d8cdb78070b4c55a, dout_ready=1
//     -> words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on cycles t+1..t+4, dout_last only on 4th.
//   2 Back-pressure: same block, dout_ready toggling 1,0,0,1,0,1,1 -> each word stable while
//     stalled, exactly 4 handshakes, core_out_ready stays 0 until cycle after last handshake.
//   3 Back-to-back: core_cipher_valid held high with 2 blocks -> second fetch exactly 1 cycle
//     after last word of first block; no word duplicated/dropped.
//   4 Share invariance: d=3, 16 random sharings of the same ciphertext -> identical dout stream.
//   5 Reset mid-block after word 1 accepted -> dout_valid=0, core_out_ready=1 cycle after rst
//     drops, data reg=0; next block streams from word 0.
//   6 Spurious dout_ready in EMPTY and core data changes outside fetch -> no output, no capture.

Source files
------------

// File: rtl/mskaes_out_unmask_serializer_if.sv
// Bus bundle between the masked AES core output, the unmask/serializer stage
// and the host-side word port.
//   core_cipher_valid / core_out_ready / core_sh_data_out : core-side fetch (sticky valid)
//   dout_valid / dout_ready / dout / dout_last            : host-side word stream
//   busy                                                   : a block is held
// slave  : view of the serializer itself
// master : view of the surrounding environment (core + host)
interface mskaes_out_unmask_serializer_if #(
  parameter int d    = 2,
  parameter int BLK  = 128,
  parameter int WORD = 32
);
  logic               core_cipher_valid;
  logic               core_out_ready;
  logic [BLK*d-1:0]   core_sh_data_out;
  logic               dout_valid;
  logic               dout_ready;
  logic [WORD-1:0]    dout;
  logic               dout_last;
  logic               busy;

  modport slave (
    input  core_cipher_valid, core_sh_data_out, dout_ready,
    output core_out_ready, dout_valid, dout, dout_last, busy
  );

  modport master (
    output core_cipher_valid, core_sh_data_out, dout_ready,
    input  core_out_ready, dout_valid, dout, dout_last, busy
  );
endinterface

// File: rtl/mskaes_out_unmask_serializer.sv
// Unmask + serialize stage after the masked AES core.
// Fetches one d-share masked ciphertext, XOR-recombines the shares straight into
// the capture register, then streams the block as BLK/WORD words, MSW first.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport (core fetch side + host word side + busy)
// Handshake outputs come from registers only, so dout_ready never reaches
// core_out_ready combinationally.
module mskaes_out_unmask_serializer #(
  parameter int d    = 2,
  parameter int BLK  = 128,
  parameter int WORD = 32
) (
  input  logic clk,
  input  logic rst,
  mskaes_out_unmask_serializer_if.slave bus
);
  localparam int NW = BLK / WORD;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BLK-1:0]  data_q, data_d;
  logic            rdy_q;

  // Share recombination happens only here, at the capture register input.
  logic [BLK-1:0]  unmasked;
  for (genvar i = 0; i < BLK; i++) begin : g_unmask
    assign unmasked[i] = ^bus.core_sh_data_out[i*d +: d];
  end

  logic fetch, hs, last_w;
  assign fetch  = (state_q == EMPTY) & rdy_q & bus.core_cipher_valid;
  assign hs     = (state_q == SEND) & bus.dout_ready;
  assign last_w = (cnt_q == CW'(NW-1));

  // State register. rdy_q tracks "next state is EMPTY" but is forced low in
  // reset, so the core only sees ready from the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdy_q   <= (state_d == EMPTY);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (fetch) begin
          data_d  = unmasked;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last_w) begin
            // Plaintext-derived data does not linger once the block is out.
            data_d  = '0;
            cnt_d   = '0;
            state_d = EMPTY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output decode. Word 0 is the most significant slice of the block.
  logic [NW-1:0][WORD-1:0] words;
  assign words = data_q;

  always_comb begin
    bus.core_out_ready = rdy_q;
    bus.dout_valid     = (state_q == SEND);
    bus.dout           = words[CW'(NW-1) - cnt_q];
    bus.dout_last      = (state_q == SEND) & last_w;
    bus.busy           = (state_q != EMPTY);
  end
endmodule

// File: tb/tb_mskaes_out_unmask_serializer.sv
module tb_mskaes_out_unmask_serializer;
  localparam int BLK  = 128;
  localparam int WORD = 32;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mskaes_out_unmask_serializer_if #(.d(2), .BLK(BLK), .WORD(WORD)) if2 ();
  mskaes_out_unmask_serializer_if #(.d(3), .BLK(BLK), .WORD(WORD)) if3 ();

  mskaes_out_unmask_serializer #(.d(2), .BLK(BLK), .WORD(WORD)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));
  mskaes_out_unmask_serializer #(.d(3), .BLK(BLK), .WORD(WORD)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs2   = 0;
  logic [32:0] q2[$];
  logic [32:0] q3[$];
  int f2_cyc[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [2*BLK-1:0] share2(input logic [127:0] ct, input logic [127:0] r);
    logic [2*BLK-1:0] v;
    logic [127:0] s1;
    s1 = r ^ ct;
    for (int i = 0; i < BLK; i++) begin
      v[i*2]   = r[i];
      v[i*2+1] = s1[i];
    end
    return v;
  endfunction

  function automatic logic [3*BLK-1:0] share3(input logic [127:0] ct, input logic [127:0] r0,
                                              input logic [127:0] r1);
    logic [3*BLK-1:0] v;
    logic [127:0] s2;
    s2 = ct ^ r0 ^ r1;
    for (int i = 0; i < BLK; i++) begin
      v[i*3]   = r0[i];
      v[i*3+1] = r1[i];
      v[i*3+2] = s2[i];
    end
    return v;
  endfunction

  // Expected word stream for one block: {last, word}, word 0 = bits [127:96].
  task automatic push_exp(input bit which, input logic [127:0] ct);
    for (int k = 0; k < 4; k++) begin
      if (which) q3.push_back({k == 3, ct[127-32*k -: 32]});
      else       q2.push_back({k == 3, ct[127-32*k -: 32]});
    end
  endtask

  // Wait (bounded) until the fetch edge; returns just after that edge.
  task automatic wait_fetch(input bit which, input string tag);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (which ? (if3.core_cipher_valid && if3.core_out_ready)
                : (if2.core_cipher_valid && if2.core_out_ready)) got = 1;
    end
    if (!got) check({tag, "_fetch_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit which, input string tag);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (which ? if3.core_out_ready : if2.core_out_ready) got = 1;
    end
    if (!got) check({tag, "_idle_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // d=2 monitor: scoreboard pop on handshake, word stability while stalled.
  initial begin
    logic        held;
    logic [32:0] hval;
    held = 0;
    hval = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (if2.core_cipher_valid && if2.core_out_ready) f2_cyc.push_back(cyc);
        if (held) check("hold2", {if2.dout_valid, if2.dout_last, if2.dout}, {1'b1, hval});
        if (if2.dout_valid && if2.dout_ready) begin
          hs2++;
          if (q2.size() == 0) check("extra_word2", {if2.dout_last, if2.dout}, 33'h1_dead_beef);
          else check("word2", {if2.dout_last, if2.dout}, q2.pop_front());
        end
        held = if2.dout_valid && !if2.dout_ready;
        hval = {if2.dout_last, if2.dout};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && if3.dout_valid && if3.dout_ready) begin
      if (q3.size() == 0) check("extra_word3", {if3.dout_last, if3.dout}, 33'h1_dead_beef);
      else check("word3", {if3.dout_last, if3.dout}, q3.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct, ctb;
    logic [6:0]   pat;
    int           hs_base;
    rst = 1;
    if2.core_cipher_valid = 0; if2.core_sh_data_out = '0; if2.dout_ready = 0;
    if3.core_cipher_valid = 0; if3.core_sh_data_out = '0; if3.dout_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  if2.core_out_ready, 0);
    check("rst_valid",  if2.dout_valid, 0);
    check("rst_dout",   if2.dout, 0);
    check("rst_last",   if2.dout_last, 0);
    check("rst_busy",   if2.busy, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("post_rst_ready", if2.core_out_ready, 1);

    // 1: FIPS-197 C.1, full-rate drain, latency and dout_last placement.
    if2.dout_ready = 1;
    if2.core_sh_data_out = share2(CT_C1, rnd128());
    if2.core_cipher_valid = 1;
    push_exp(0, CT_C1);
    wait_fetch(0, "c1");
    if2.core_cipher_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("c1_valid", if2.dout_valid, 1);
      check("c1_last",  if2.dout_last, (k == 3));
      check("c1_ready_low", if2.core_out_ready, 0);
    end
    @(negedge clk);
    check("c1_ready_back", if2.core_out_ready, 1);
    check("c1_valid_off",  if2.dout_valid, 0);
    @(posedge clk); #1;

    // 2: back-pressure with dout_ready pattern 1,0,0,1,0,1,1.
    pat = 7'b1101001; // bit k = cycle k
    if2.dout_ready = 0;
    if2.core_sh_data_out = share2(CT_C1, rnd128());
    if2.core_cipher_valid = 1;
    push_exp(0, CT_C1);
    wait_fetch(0, "bp");
    if2.core_cipher_valid = 0;
    hs_base = hs2;
    for (int k = 0; k < 7; k++) begin
      if2.dout_ready = pat[k];
      @(negedge clk);
      check("bp_ready_low", if2.core_out_ready, 0);
      @(posedge clk); #1;
    end
    if2.dout_ready = 1;
    @(negedge clk);
    check("bp_handshakes", hs2 - hs_base, 4);
    check("bp_ready_back", if2.core_out_ready, 1);
    @(posedge clk); #1;

    // 3: back-to-back blocks with core_cipher_valid held high.
    ct  = rnd128();
    ctb = rnd128();
    f2_cyc.delete();
    if2.core_sh_data_out = share2(ct, rnd128());
    if2.core_cipher_valid = 1;
    push_exp(0, ct);
    push_exp(0, ctb);
    wait_fetch(0, "b2b_a");
    if2.core_sh_data_out = share2(ctb, rnd128());
    wait_fetch(0, "b2b_b");
    if2.core_cipher_valid = 0;
    if (f2_cyc.size() == 2) check("b2b_gap", f2_cyc[1] - f2_cyc[0], 5);
    else check("b2b_fetches", f2_cyc.size(), 2);
    wait_idle(0, "b2b");

    // 4: d=3 share invariance, 16 random sharings of one ciphertext.
    ct = rnd128();
    for (int s = 0; s < 16; s++) begin
      if3.core_sh_data_out = share3(ct, rnd128(), rnd128());
      if3.core_cipher_valid = 1;
      push_exp(1, ct);
      wait_fetch(1, "inv");
      if3.core_cipher_valid = 0;
      if3.core_sh_data_out = rnd128() == 0 ? '0 : {3{rnd128()}};
      wait_idle(1, "inv");
    end

    // 5: reset after word 1 accepted.
    ct = rnd128();
    if2.core_sh_data_out = share2(ct, rnd128());
    if2.core_cipher_valid = 1;
    push_exp(0, ct);
    wait_fetch(0, "mrst");
    if2.core_cipher_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("mrst_pending", q2.size(), 2);
    q2.delete();
    @(negedge clk);
    check("mrst_valid", if2.dout_valid, 0);
    check("mrst_busy",  if2.busy, 0);
    check("mrst_dout",  if2.dout, 0);
    check("mrst_ready_rst", if2.core_out_ready, 0);
    @(negedge clk);
    check("mrst_ready", if2.core_out_ready, 1);
    @(posedge clk); #1;
    ct = rnd128();
    if2.core_sh_data_out = share2(ct, rnd128());
    if2.core_cipher_valid = 1;
    push_exp(0, ct);
    wait_fetch(0, "mrst_next");
    if2.core_cipher_valid = 0;
    wait_idle(0, "mrst_next");

    // 6: spurious dout_ready and data changes while EMPTY.
    for (int k = 0; k < 6; k++) begin
      if2.dout_ready = k[0];
      if2.core_sh_data_out = {rnd128(), rnd128()};
      @(negedge clk);
      check("spur_valid", if2.dout_valid, 0);
      check("spur_busy",  if2.busy, 0);
      check("spur_dout",  if2.dout, 0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("q2_empty", q2.size(), 0);
    check("q3_empty", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
